// File: rtl/route_pkg.sv
// Shared definitions for the route/feedback bank sequencer: FSM state
// encoding, bank geometry constants and the load-select encoding.
package route_pkg;

    localparam int ROUTE_WORDS  = 10;
    localparam int ROUTE_ADDR_W = 4;
    localparam int ROUTE_DATA_W = 16;

    // Sequencer states, in the order a normal pass visits them.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        READ  = 3'd2,
        WAIT  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } route_state_t;

    // Source of the data the bank captures when RegLoadEn is high.
    typedef enum logic {
        SEL_M1       = 1'b0,
        SEL_FEEDBACK = 1'b1
    } load_sel_t;

endpackage

// File: rtl/route_seq_ctrl_if.sv
// Load/read interface of the route/feedback register bank.
// master = sequencer (drives the bank controls, receives the LUT result);
// slave  = bank + LUT side.
interface route_seq_ctrl_if import route_pkg::*; #(
    parameter int ADDR_W = ROUTE_ADDR_W,
    parameter int DATA_W = ROUTE_DATA_W
) ();

    logic              gate;
    logic              reg_load_en;
    logic              reg_load_sel;
    logic [ADDR_W-1:0] addr;
    logic              data_out_sel;
    logic [DATA_W-1:0] sig_feedback;
    logic [DATA_W-1:0] lut_data;

    modport master (
        output gate,
        output reg_load_en,
        output reg_load_sel,
        output addr,
        output data_out_sel,
        output sig_feedback,
        input  lut_data
    );

    modport slave (
        input  gate,
        input  reg_load_en,
        input  reg_load_sel,
        input  addr,
        input  data_out_sel,
        input  sig_feedback,
        output lut_data
    );

endinterface

// File: rtl/route_gate_sync.sv
// Bank clock-enable register. Samples the access flag on the falling edge so
// that the enable is already settled before clk rises and stays constant for
// the whole high phase: clk & gate can then only rise together with clk.
// Reset clears the enable asynchronously so the bank sees no further edge.
module route_gate_sync (
    input  logic clk,
    input  logic rst,
    input  logic access,
    output logic gate
);

    // Falling-edge enable register with asynchronous clear.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            gate <= 1'b0;
        end else begin
            gate <= access;
        end
    end

endmodule

// File: rtl/route_seq_ctrl.sv
// Sequencer for the intermediate route/feedback register bank between M1
// and M2. On start it bulk-loads the M1 result vector, then for every word
// reads it out through the sigmoid LUT, captures the LUT result and writes
// it back into the same word.
//
// Optional feature macro: ROUTE_SEQ_SRAM_SRC_EN
//   When defined, a src_sram input (sampled with start) selects GSRAM as the
//   LUT source: the bulk load is skipped and data_out_sel is raised during
//   READ/WAIT. When undefined, data_out_sel is constant 0 and LOAD always runs.
module route_seq_ctrl import route_pkg::*; #(
    parameter int NUM_WORDS = ROUTE_WORDS,
    parameter int ADDR_W    = ROUTE_ADDR_W,
    parameter int DATA_W    = ROUTE_DATA_W,
    parameter int LUT_LAT   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
`ifdef ROUTE_SEQ_SRAM_SRC_EN
    input  logic src_sram,
`endif
    route_seq_ctrl_if.master bank,
    output logic busy,
    output logic done
);

    // WAIT lasts LUT_LAT+1 cycles; the counter runs 0..LUT_LAT.
    localparam int WAIT_W = (LUT_LAT > 0) ? $clog2(LUT_LAT + 1) : 1;

    localparam logic [ADDR_W-1:0] LAST_K    = ADDR_W'(NUM_WORDS - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(LUT_LAT);

    route_state_t      state, state_d;
    logic [ADDR_W-1:0] k, k_d;
    logic [WAIT_W-1:0] wait_cnt, wait_d;
    logic              sram_mode, sram_d;
    logic              fb_load;
    logic              access;
    logic              src_req;

`ifdef ROUTE_SEQ_SRAM_SRC_EN
    assign src_req = src_sram;
`else
    assign src_req = 1'b0;
`endif

    // State, word counter, LUT-wait counter and source-mode registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of all the others.
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            wait_cnt  <= '0;
            sram_mode <= 1'b0;
        end else begin
            state     <= state_d;
            k         <= k_d;
            wait_cnt  <= wait_d;
            sram_mode <= sram_d;
        end
    end

    // Next-state and counter update; start is only honoured in IDLE.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d = state;
        k_d     = k;
        wait_d  = wait_cnt;
        sram_d  = sram_mode;
        fb_load = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    k_d     = '0;
                    wait_d  = '0;
                    sram_d  = src_req;
                    state_d = src_req ? READ : LOAD;
                end
            end
            LOAD: begin
                state_d = READ;
            end
            READ: begin
                wait_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (wait_cnt == LAST_WAIT) begin
                    fb_load = 1'b1;
                    wait_d  = '0;
                    state_d = WRITE;
                end else begin
                    wait_d = wait_cnt + 1'b1;
                end
            end
            WRITE: begin
                if (k == LAST_K) begin
                    state_d = DONE;
                end else begin
                    k_d     = k + 1'b1;
                    state_d = READ;
                end
            end
            DONE: begin
                k_d     = '0;
                sram_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                k_d     = '0;
                wait_d  = '0;
                sram_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Bank control decode from the registered state and word counter.
    always_comb begin
        access            = 1'b0;
        bank.reg_load_en  = 1'b0;
        bank.reg_load_sel = SEL_M1;
        bank.addr         = '0;
        bank.data_out_sel = 1'b0;
        busy              = 1'b0;
        done              = 1'b0;

        case (state)
            LOAD: begin
                access            = 1'b1;
                bank.reg_load_en  = 1'b1;
                bank.reg_load_sel = SEL_M1;
                busy              = 1'b1;
            end
            READ: begin
                access            = 1'b1;
                bank.addr         = k;
                bank.data_out_sel = sram_mode;
                busy              = 1'b1;
            end
            WAIT: begin
                bank.addr         = k;
                bank.data_out_sel = sram_mode;
                busy              = 1'b1;
            end
            WRITE: begin
                access            = 1'b1;
                bank.reg_load_en  = 1'b1;
                bank.reg_load_sel = SEL_FEEDBACK;
                bank.addr         = k;
                busy              = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                access = 1'b0;
            end
        endcase
    end

    // Feedback word: holds the LUT result captured on the last WAIT cycle so
    // it is stable for the whole WRITE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank.sig_feedback <= '0;
        end else if (fb_load) begin
            bank.sig_feedback <= bank.lut_data;
        end
    end

    route_gate_sync u_gate_sync (
        .clk    (clk),
        .rst    (rst),
        .access (access),
        .gate   (bank.gate)
    );

    // The word counter never leaves the bank and done is a single-cycle pulse.
    a_k_range: assert property (@(posedge clk) disable iff (rst) k <= LAST_K);
    a_done_pulse: assert property (@(posedge clk) disable iff (rst) done |=> !done);

endmodule
